// File: rtl/riscv_pkg.sv
// Shared FSM state type and default parameter values for the program sequencer.
package riscv_pkg;
   localparam int unsigned DEF_DW         = 32;
   localparam int unsigned DEF_AW         = 10;
   localparam int unsigned DEF_CW         = 16;
   localparam int unsigned DEF_MAX_CYCLES = 2000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;
endpackage

// File: rtl/riscv_watchdog.sv
// Run-cycle counter: cleared on start, 1 on entry to RUN, counts up and sticks
// at MAX_CYCLES; expired_o flags that the limit has been reached.
module riscv_watchdog #(
   parameter int unsigned CW         = riscv_pkg::DEF_CW,
   parameter int unsigned MAX_CYCLES = riscv_pkg::DEF_MAX_CYCLES
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          first_i,
   input  logic          inc_i,
   output logic [CW-1:0] cycles_o,
   output logic          expired_o
);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, then RUN entry, then saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (first_i) begin
         cnt_d = CW'(1);
      end else if (inc_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cycles_o  = cnt_q;
   assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/riscv_prog_sequencer.sv
// Program sequencer: streams a program into instruction memory, releases the
// core, and watches for halt or watchdog expiry.
module riscv_prog_sequencer #(
   parameter int unsigned DW         = riscv_pkg::DEF_DW,
   parameter int unsigned AW         = riscv_pkg::DEF_AW,
   parameter int unsigned CW         = riscv_pkg::DEF_CW,
   parameter int unsigned MAX_CYCLES = riscv_pkg::DEF_MAX_CYCLES
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          core_run,
   input  logic          core_halted,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic          overflow,
   output logic [CW-1:0] cycles,
   output logic [AW:0]   words
);
   import riscv_pkg::*;

   seq_state_e    state_q, state_d;
   logic [AW:0]   words_q, words_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic          overflow_q, overflow_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          wd_clr, wd_first, wd_inc, wd_expired;
   logic          accept;

   // Words are refused in the abort cycle so abort cannot race a handshake.
   assign ld_ready = (state_q == ST_LOAD) && !abort;
   assign accept   = ld_valid && ld_ready;

   riscv_watchdog #(
      .CW         (CW),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_watchdog (
      .clk_i     (clk1),
      .rst_ni    (rst_n),
      .clr_i     (wd_clr),
      .first_i   (wd_first),
      .inc_i     (wd_inc),
      .cycles_o  (cycles),
      .expired_o (wd_expired)
   );

   // Next state, counters, flags and write pipeline; abort pre-empts everything.
   always_comb begin
      state_d     = state_q;
      words_d     = words_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      overflow_d  = overflow_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wd_clr      = 1'b0;
      wd_first    = 1'b0;
      wd_inc      = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d    = ST_LOAD;
                  words_d    = '0;
                  done_d     = 1'b0;
                  timeout_d  = 1'b0;
                  overflow_d = 1'b0;
                  wd_clr     = 1'b1;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = words_q[AW-1:0];
                  mem_wdata_d = ld_data;
                  words_d     = words_q + (AW+1)'(1);
                  if (ld_last) begin
                     state_d  = ST_RUN;
                     wd_first = 1'b1;
                  end else if (&words_q[AW-1:0]) begin
                     state_d    = ST_DONE;
                     overflow_d = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (core_halted) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (wd_expired) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end else begin
                  wd_inc = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         words_q     <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         overflow_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         words_q     <= words_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         overflow_q  <= overflow_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign core_run  = (state_q == ST_RUN);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign overflow  = overflow_q;
   assign words     = words_q;
endmodule

// File: tb/tb_riscv_prog_sequencer.sv
// Bench for riscv_prog_sequencer: a full-size instance with a short watchdog
// and a 4-word instance for the overflow boundary, sharing one stimulus.
module tb_riscv_prog_sequencer;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 10;
  localparam int unsigned AWB  = 2;
  localparam int unsigned CW   = 16;
  localparam int unsigned MAXC = 20;

  logic clk1 = 1'b0;
  logic rst_n, start, abort, ld_valid, ld_last, core_halted;
  logic [DW-1:0] ld_data;

  logic           ld_ready_a, mem_we_a, core_run_a, busy_a, done_a, timeout_a, overflow_a;
  logic [AW-1:0]  mem_addr_a;
  logic [DW-1:0]  mem_wdata_a;
  logic [CW-1:0]  cycles_a;
  logic [AW:0]    words_a;

  logic           ld_ready_b, mem_we_b, core_run_b, busy_b, done_b, timeout_b, overflow_b;
  logic [AWB-1:0] mem_addr_b;
  logic [DW-1:0]  mem_wdata_b;
  logic [CW-1:0]  cycles_b;
  logic [AWB:0]   words_b;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] prog [0:15];

  always #5 clk1 = ~clk1;

  riscv_prog_sequencer #(.DW(DW), .AW(AW), .CW(CW), .MAX_CYCLES(MAXC)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .core_run(core_run_a), .core_halted(core_halted), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .overflow(overflow_a), .cycles(cycles_a), .words(words_a));

  riscv_prog_sequencer #(.DW(DW), .AW(AWB), .CW(CW), .MAX_CYCLES(MAXC)) u_small (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .core_run(core_run_b), .core_halted(core_halted), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .overflow(overflow_b), .cycles(cycles_b), .words(words_b));

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    core_halted = 1'b0; ld_data = '0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy_a !== 1'b0 || core_run_a !== 1'b0 || mem_we_a !== 1'b0) begin
      bad++;
      $display("FAIL go_idle: busy=%b run=%b we=%b want 0 0 0", busy_a, core_run_a, mem_we_a);
    end
  endtask

  // Start pulse from IDLE/DONE: LOAD with every counter and flag cleared.
  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy_a !== 1'b1 || words_a !== '0 || cycles_a !== '0 || done_a !== 1'b0 ||
        timeout_a !== 1'b0 || overflow_a !== 1'b0) begin
      bad++;
      $display("FAIL start_clear: busy=%b words=%0d cycles=%0d done=%b to=%b ovf=%b want 1 0 0 0 0 0",
               busy_a, words_a, cycles_a, done_a, timeout_a, overflow_a);
    end
  endtask

  // Streams prog[0..n-1]; mode 0 valid always, 1 toggling, 2 random.
  // noisy adds start pulses and core_halted noise, both of which must be ignored.
  task automatic load_prog(input int n, input int mode, input bit noisy);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < n && guard < 200) begin
      guard++;
      case (mode)
        0:       ld_valid = 1'b1;
        1:       ld_valid = guard[0];
        default: ld_valid = 1'($urandom_range(0, 1));
      endcase
      ld_data     = prog[idx];
      ld_last     = (idx == n - 1);
      start       = noisy && ($urandom_range(0, 3) == 0);
      core_halted = noisy && ($urandom_range(0, 1) == 1);
      #1;
      total++;
      if (ld_ready_a !== 1'b1 || core_run_a !== 1'b0) begin
        bad++;
        $display("FAIL load_state: ready=%b run=%b want 1 0", ld_ready_a, core_run_a);
      end
      hs = ld_valid;
      tick();
      total++;
      if (hs) begin
        if (mem_we_a !== 1'b1 || mem_addr_a !== AW'(idx) || mem_wdata_a !== prog[idx]) begin
          bad++;
          $display("FAIL load_write: we=%b addr=%0d data=%h want 1 %0d %h",
                   mem_we_a, mem_addr_a, mem_wdata_a, idx, prog[idx]);
        end
        idx++;
      end else if (mem_we_a !== 1'b0) begin
        bad++;
        $display("FAIL load_nowrite: we=%b want 0", mem_we_a);
      end
      total++;
      if (words_a !== (AW+1)'(idx)) begin
        bad++;
        $display("FAIL load_words: got %0d want %0d", words_a, idx);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0; core_halted = 1'b0;
    total++;
    if (idx != n) begin
      bad++;
      $display("FAIL load_budget: accepted %0d want %0d", idx, n);
    end else if (core_run_a !== 1'b1 || mem_we_a !== 1'b1) begin
      bad++;
      $display("FAIL run_rise: run=%b we=%b want 1 1", core_run_a, mem_we_a);
    end
  endtask

  // Runs from the first RUN cycle; halt_at=0 never halts. Then checks DONE holds.
  task automatic run_phase(input int halt_at, input bit noisy, input int n);
    int k = 1;
    bit halting = 1'b0;
    bit expire = 1'b0;
    bit exp_to;
    while (k <= 40) begin
      total++;
      if (core_run_a !== 1'b1 || cycles_a !== CW'(k) || done_a !== 1'b0) begin
        bad++;
        $display("FAIL run_cycle: run=%b cycles=%0d done=%b want 1 %0d 0",
                 core_run_a, cycles_a, done_a, k);
      end
      halting     = (k == halt_at);
      expire      = (k == MAXC);
      core_halted = halting;
      start       = noisy && ($urandom_range(0, 3) == 0);
      tick();
      total++;
      if (mem_we_a !== 1'b0) begin
        bad++;
        $display("FAIL run_we: got %b want 0", mem_we_a);
      end
      if (halting || expire) break;
      k++;
    end
    core_halted = 1'b0; start = 1'b0;
    exp_to = expire && !halting;
    total++;
    if (core_run_a !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b0 ||
        timeout_a !== exp_to || cycles_a !== CW'(k)) begin
      bad++;
      $display("FAIL run_end: run=%b done=%b busy=%b to=%b cycles=%0d want 0 1 0 %b %0d",
               core_run_a, done_a, busy_a, timeout_a, cycles_a, exp_to, k);
    end
    repeat (2) begin
      core_halted = 1'($urandom_range(0, 1));
      ld_valid    = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (done_a !== 1'b1 || timeout_a !== exp_to || cycles_a !== CW'(k) ||
          words_a !== (AW+1)'(n) || ld_ready_a !== 1'b0 || core_run_a !== 1'b0 || mem_we_a !== 1'b0) begin
        bad++;
        $display("FAIL done_hold: done=%b to=%b cycles=%0d words=%0d ready=%b run=%b we=%b want 1 %b %0d %0d 0 0 0",
                 done_a, timeout_a, cycles_a, words_a, ld_ready_a, core_run_a, mem_we_a, exp_to, k, n);
      end
    end
    core_halted = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({ld_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, core_run_a, busy_a, done_a,
         timeout_a, overflow_a, cycles_a, words_a} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs not all zero (we=%b run=%b busy=%b words=%0d cycles=%0d)",
               mem_we_a, core_run_a, busy_a, words_a, cycles_a);
    end
    total++;
    if ({ld_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, core_run_b, busy_b, done_b,
         timeout_b, overflow_b, cycles_b, words_b} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs not all zero (we=%b run=%b busy=%b words=%0d)",
               mem_we_b, core_run_b, busy_b, words_b);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (busy_a !== 1'b0 || ld_ready_a !== 1'b0 || words_a !== '0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b ready=%b words=%0d want 0 0 0", busy_a, ld_ready_a, words_a);
    end
  endtask

  task automatic test_fixed_program();
    prog[0] = 32'h48010002; prog[1] = 32'h4802000a; prog[2] = 32'h28411800;
    prog[3] = 32'h34240005; prog[4] = 32'hfc000000;
    go_idle();
    start_seq();
    load_prog(5, 0, 1'b0);
    run_phase(9, 1'b0, 5);
  endtask

  task automatic test_timeout();
    prog[0] = $urandom; prog[1] = $urandom;
    start_seq();
    load_prog(2, 2, 1'b0);
    run_phase(0, 1'b0, 2);
    start_seq();
    load_prog(2, 0, 1'b0);
    run_phase(int'(MAXC), 1'b0, 2);
  endtask

  task automatic test_overflow();
    int idx = 0;
    bit exp_ready;
    for (int unsigned i = 0; i < 8; i++) prog[i] = $urandom;
    go_idle();
    start_seq();
    repeat (6) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = prog[idx];
      exp_ready = (idx < (1 << AWB));
      #1;
      total++;
      if (ld_ready_b !== exp_ready) begin
        bad++;
        $display("FAIL ovf_ready: got %b want %b", ld_ready_b, exp_ready);
      end
      tick();
      total++;
      if (exp_ready) begin
        if (mem_we_b !== 1'b1 || mem_addr_b !== AWB'(idx) || mem_wdata_b !== prog[idx]) begin
          bad++;
          $display("FAIL ovf_write: we=%b addr=%0d data=%h want 1 %0d %h",
                   mem_we_b, mem_addr_b, mem_wdata_b, idx, prog[idx]);
        end
        idx++;
      end else if (mem_we_b !== 1'b0) begin
        bad++;
        $display("FAIL ovf_nowrite: got %b want 0", mem_we_b);
      end
      total++;
      if (core_run_b !== 1'b0) begin
        bad++;
        $display("FAIL ovf_run: got %b want 0", core_run_b);
      end
    end
    ld_valid = 1'b0;
    total++;
    if (overflow_b !== 1'b1 || words_b !== (AWB+1)'(4) || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL ovf_end: ovf=%b words=%0d busy=%b want 1 4 0", overflow_b, words_b, busy_b);
    end
    go_idle();
  endtask

  task automatic test_toggle_noise();
    for (int unsigned i = 0; i < 6; i++) prog[i] = $urandom;
    start_seq();
    load_prog(6, 1, 1'b1);
    run_phase(int'($urandom_range(3, 15)), 1'b1, 6);
  endtask

  task automatic test_reset_abort();
    for (int unsigned i = 0; i < 3; i++) prog[i] = $urandom;
    start_seq();
    load_prog(3, 2, 1'b0);
    tick(); tick();
    total++;
    if (cycles_a !== CW'(3) || core_run_a !== 1'b1) begin
      bad++;
      $display("FAIL run3: cycles=%0d run=%b want 3 1", cycles_a, core_run_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ld_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, core_run_a, busy_a, done_a,
         timeout_a, overflow_a, cycles_a, words_a} !== '0) begin
      bad++;
      $display("FAIL reset_run: run=%b we=%b busy=%b cycles=%0d words=%0d want all 0",
               core_run_a, mem_we_a, busy_a, cycles_a, words_a);
    end
    #1 rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL start_after_reset: busy=%b want 1", busy_a);
    end
    repeat (2) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = $urandom;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; ld_valid = 1'b0;
    total++;
    if (busy_a !== 1'b0 || core_run_a !== 1'b0 || mem_we_a !== 1'b0 ||
        words_a !== (AW+1)'(2) || ld_ready_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_load: busy=%b run=%b we=%b words=%0d ready=%b want 0 0 0 2 0",
               busy_a, core_run_a, mem_we_a, words_a, ld_ready_a);
    end
    start_seq();
    load_prog(2, 0, 1'b0);
    tick(); tick();
    abort = 1'b1; core_halted = 1'b1;
    tick();
    abort = 1'b0; core_halted = 1'b0;
    total++;
    if (core_run_a !== 1'b0 || busy_a !== 1'b0 || cycles_a !== CW'(3) || done_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_run: run=%b busy=%b cycles=%0d done=%b want 0 0 3 0",
               core_run_a, busy_a, cycles_a, done_a);
    end
  endtask

  task automatic test_back_to_back();
    int n, mode;
    for (int unsigned r = 0; r < 6; r++) begin
      n    = (r == 0) ? 1 : int'($urandom_range(1, 8));
      mode = int'($urandom_range(0, 2));
      for (int unsigned i = 0; i < n; i++) prog[i] = $urandom;
      start_seq();
      load_prog(n, mode, 1'b1);
      run_phase(int'($urandom_range(1, 25)), 1'b1, n);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_program();
    test_timeout();
    test_overflow();
    test_toggle_noise();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "time limit");
  end
endmodule
